// File: rtl/elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : elevator_scheduler
// Description : Single-car SCAN scheduler. It latches floor calls, steps the
//               car one floor per travel interval and sequences the door.
// Revision    : 1.0
// ============================================================================
module elevator_scheduler #(
    parameter int NUM_FLOORS    = 8,
    parameter int FLOOR_W       = 3,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [FLOOR_W-1:0]    req_floor,
    input  logic                  estop,
    output logic                  motor_up,
    output logic                  motor_down,
    output logic                  door_open,
    output logic                  door_wait,
    output logic                  door_close,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [2:0]            state
);

    localparam logic [2:0] c_st_idle       = 3'd0;
    localparam logic [2:0] c_st_move_up    = 3'd1;
    localparam logic [2:0] c_st_move_down  = 3'd2;
    localparam logic [2:0] c_st_door_open  = 3'd3;
    localparam logic [2:0] c_st_door_wait  = 3'd4;
    localparam logic [2:0] c_st_door_close = 3'd5;
    localparam logic [2:0] c_st_estop      = 3'd6;

    localparam int c_travel_w = $clog2(TRAVEL_CYCLES + 1);
    localparam int c_door_w   = $clog2(DOOR_CYCLES + 1);

    localparam logic [FLOOR_W:0]      c_num_floors  = (FLOOR_W+1)'(NUM_FLOORS);
    localparam logic [FLOOR_W-1:0]    c_top_floor   = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [c_travel_w-1:0] c_travel_load = c_travel_w'(TRAVEL_CYCLES);
    localparam logic [c_door_w-1:0]   c_door_load   = c_door_w'(DOOR_CYCLES);
    localparam logic [NUM_FLOORS-1:0] c_bit0        = NUM_FLOORS'(1);

    logic [2:0]            r_state;
    logic [FLOOR_W-1:0]    r_cur_floor;
    logic                  r_dir_up;
    logic [NUM_FLOORS-1:0] r_pending;
    logic [c_travel_w-1:0] r_travel_cnt;
    logic [c_door_w-1:0]   r_door_cnt;

    logic [2:0]            w_state_nxt;
    logic [FLOOR_W-1:0]    w_floor_nxt;
    logic                  w_dir_nxt;
    logic [c_travel_w-1:0] w_travel_nxt;
    logic [c_door_w-1:0]   w_door_nxt;
    logic [NUM_FLOORS-1:0] w_clr;

    logic                  w_req_ok;
    logic                  w_door_hold;
    logic [NUM_FLOORS-1:0] w_set;
    logic [NUM_FLOORS-1:0] w_here_mask;
    logic [NUM_FLOORS-1:0] w_below_mask;
    logic [NUM_FLOORS-1:0] w_above_mask;
    logic                  w_here;
    logic                  w_any_above;
    logic                  w_any_below;
    logic                  w_arrive_up;
    logic                  w_arrive_dn;

    // A call for the floor the door is already open at re-arms the door
    // timer instead of queueing a second visit.
    assign w_req_ok    = req_valid && ({1'b0, req_floor} < c_num_floors);
    assign w_door_hold = w_req_ok && (req_floor == r_cur_floor) &&
                         ((r_state == c_st_door_open) || (r_state == c_st_door_wait));
    assign w_set       = (w_req_ok && !w_door_hold) ? (c_bit0 << req_floor) : '0;

    assign w_here_mask  = c_bit0 << r_cur_floor;
    assign w_below_mask = w_here_mask - c_bit0;
    assign w_above_mask = ~(w_below_mask | w_here_mask);
    assign w_here       = |(r_pending & w_here_mask);
    assign w_any_above  = |(r_pending & w_above_mask);
    assign w_any_below  = |(r_pending & w_below_mask);
    assign w_arrive_up  = |((r_pending | w_set) & (w_here_mask << 1));
    assign w_arrive_dn  = |((r_pending | w_set) & (w_here_mask >> 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_cur_floor  <= '0;
            r_dir_up     <= 1'b1;
            r_pending    <= '0;
            r_travel_cnt <= '0;
            r_door_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cur_floor  <= w_floor_nxt;
            r_dir_up     <= w_dir_nxt;
            r_pending    <= (r_pending & ~w_clr) | w_set;
            r_travel_cnt <= w_travel_nxt;
            r_door_cnt   <= w_door_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_floor_nxt  = r_cur_floor;
        w_dir_nxt    = r_dir_up;
        w_travel_nxt = r_travel_cnt;
        w_door_nxt   = r_door_cnt;
        w_clr        = '0;
        if (estop) begin
            w_state_nxt  = c_st_estop;
            w_travel_nxt = '0;
            w_door_nxt   = '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_here) begin
                        w_state_nxt = c_st_door_open;
                    end else if (r_dir_up && w_any_above) begin
                        w_state_nxt  = c_st_move_up;
                        w_travel_nxt = c_travel_load;
                    end else if (!r_dir_up && w_any_below) begin
                        w_state_nxt  = c_st_move_down;
                        w_travel_nxt = c_travel_load;
                    end else if (w_any_below) begin
                        w_dir_nxt    = 1'b0;
                        w_state_nxt  = c_st_move_down;
                        w_travel_nxt = c_travel_load;
                    end else if (w_any_above) begin
                        w_dir_nxt    = 1'b1;
                        w_state_nxt  = c_st_move_up;
                        w_travel_nxt = c_travel_load;
                    end
                end
                c_st_move_up: begin
                    if (r_cur_floor == c_top_floor) begin
                        w_state_nxt  = c_st_idle;
                        w_travel_nxt = '0;
                    end else if (r_travel_cnt <= c_travel_w'(1)) begin
                        w_floor_nxt = r_cur_floor + FLOOR_W'(1);
                        if (w_arrive_up) begin
                            w_state_nxt  = c_st_door_open;
                            w_travel_nxt = '0;
                        end else begin
                            w_travel_nxt = c_travel_load;
                        end
                    end else begin
                        w_travel_nxt = r_travel_cnt - c_travel_w'(1);
                    end
                end
                c_st_move_down: begin
                    if (r_cur_floor == '0) begin
                        w_state_nxt  = c_st_idle;
                        w_travel_nxt = '0;
                    end else if (r_travel_cnt <= c_travel_w'(1)) begin
                        w_floor_nxt = r_cur_floor - FLOOR_W'(1);
                        if (w_arrive_dn) begin
                            w_state_nxt  = c_st_door_open;
                            w_travel_nxt = '0;
                        end else begin
                            w_travel_nxt = c_travel_load;
                        end
                    end else begin
                        w_travel_nxt = r_travel_cnt - c_travel_w'(1);
                    end
                end
                c_st_door_open: begin
                    w_clr       = w_here_mask;
                    w_door_nxt  = c_door_load;
                    w_state_nxt = c_st_door_wait;
                end
                c_st_door_wait: begin
                    if (w_door_hold) begin
                        w_door_nxt = c_door_load;
                    end else if (r_door_cnt <= c_door_w'(1)) begin
                        w_door_nxt  = '0;
                        w_state_nxt = c_st_door_close;
                    end else begin
                        w_door_nxt = r_door_cnt - c_door_w'(1);
                    end
                end
                c_st_door_close: w_state_nxt = c_st_idle;
                c_st_estop:      w_state_nxt = c_st_idle;
                default:         w_state_nxt = c_st_idle;
            endcase
        end
    end

    // Commands depend only on the registered state so they are glitch-free.
    always_comb begin
        motor_up   = 1'b0;
        motor_down = 1'b0;
        door_open  = 1'b0;
        door_wait  = 1'b0;
        door_close = 1'b0;
        case (r_state)
            c_st_move_up:    motor_up   = 1'b1;
            c_st_move_down:  motor_down = 1'b1;
            c_st_door_open:  door_open  = 1'b1;
            c_st_door_wait: begin
                door_open = 1'b1;
                door_wait = 1'b1;
            end
            c_st_idle, c_st_door_close, c_st_estop: door_close = 1'b1;
            default: ;
        endcase
    end

    assign state     = r_state;
    assign cur_floor = r_cur_floor;
    assign dir_up    = r_dir_up;
    assign pending   = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_elevator_scheduler
// Description : Directed self-checking bench for elevator_scheduler.
// Revision    : 1.0
// ============================================================================
module tb_elevator_scheduler;

    localparam int NUM_FLOORS    = 8;
    localparam int FLOOR_W       = 4;
    localparam int TRAVEL_CYCLES = 2;
    localparam int DOOR_CYCLES   = 4;

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_up    = 3'd1;
    localparam logic [2:0] c_down  = 3'd2;
    localparam logic [2:0] c_open  = 3'd3;
    localparam logic [2:0] c_wait  = 3'd4;
    localparam logic [2:0] c_close = 3'd5;
    localparam logic [2:0] c_estop = 3'd6;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  req_valid;
    logic [FLOOR_W-1:0]    req_floor;
    logic                  estop;
    logic                  motor_up;
    logic                  motor_down;
    logic                  door_open;
    logic                  door_wait;
    logic                  door_close;
    logic [FLOOR_W-1:0]    cur_floor;
    logic                  dir_up;
    logic [NUM_FLOORS-1:0] pending;
    logic [2:0]            state;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cyc;

    always #5 clk = ~clk;

    elevator_scheduler #(
        .NUM_FLOORS   (NUM_FLOORS),
        .FLOOR_W      (FLOOR_W),
        .TRAVEL_CYCLES(TRAVEL_CYCLES),
        .DOOR_CYCLES  (DOOR_CYCLES)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_floor (req_floor),
        .estop     (estop),
        .motor_up  (motor_up),
        .motor_down(motor_down),
        .door_open (door_open),
        .door_wait (door_wait),
        .door_close(door_close),
        .cur_floor (cur_floor),
        .dir_up    (dir_up),
        .pending   (pending),
        .state     (state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [FLOOR_W-1:0] f);
        req_valid = 1'b1;
        req_floor = f;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s);
        for (int i = 0; i < 200 && state !== s; i++) tick();
        check_eq(tag, 32'(state), 32'(s));
    endtask

    task automatic wait_floor(input string tag, input logic [FLOOR_W-1:0] f);
        for (int i = 0; i < 200 && cur_floor !== f; i++) tick();
        check_eq(tag, 32'(cur_floor), 32'(f));
    endtask

    task automatic count_state(input logic [2:0] s, output int n);
        n = 0;
        while (state === s && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_floor = '0;
        estop     = 1'b0;
        tick();
        tick();

        // Reset state
        check_eq("rst_state", 32'(state), 32'(c_idle));
        check_eq("rst_floor", 32'(cur_floor), 32'd0);
        check_eq("rst_dir", 32'(dir_up), 32'd1);
        check_eq("rst_pending", 32'(pending), 32'd0);
        check_eq("rst_cmds", 32'({motor_up, motor_down, door_open, door_wait, door_close}), 32'b00001);
        rst = 1'b0;

        // Single call to floor 3 from floor 0
        request(4'd3);
        check_eq("s1_latched", 32'(pending), 32'h08);
        check_eq("s1_still_idle", 32'(state), 32'(c_idle));
        tick();
        check_eq("s1_move_up", 32'(state), 32'(c_up));
        check_eq("s1_motor_up", 32'(motor_up), 32'd1);
        count_state(c_up, n_cyc);
        check_eq("s1_up_cycles", 32'(n_cyc), 32'd6);
        check_eq("s1_floor3", 32'(cur_floor), 32'd3);
        check_eq("s1_door_open", 32'({state, door_open, door_wait}), 32'({c_open, 2'b10}));
        count_state(c_open, n_cyc);
        check_eq("s1_open_cycles", 32'(n_cyc), 32'd1);
        check_eq("s1_door_wait", 32'({state, door_open, door_wait}), 32'({c_wait, 2'b11}));
        count_state(c_wait, n_cyc);
        check_eq("s1_wait_cycles", 32'(n_cyc), 32'd4);
        check_eq("s1_close", 32'({state, door_close}), 32'({c_close, 1'b1}));
        count_state(c_close, n_cyc);
        check_eq("s1_close_cycles", 32'(n_cyc), 32'd1);
        check_eq("s1_idle", 32'(state), 32'(c_idle));
        check_eq("s1_pending0", 32'(pending), 32'd0);

        // Calls above and below while heading up: serve 5, then reverse to 1
        request(4'd5);
        request(4'd1);
        check_eq("s2_pending", 32'(pending), 32'h22);
        check_eq("s2_goes_up", 32'(state), 32'(c_up));
        wait_state("s2_open5", c_open);
        check_eq("s2_floor5", 32'(cur_floor), 32'd5);
        wait_state("s2_idle5", c_idle);
        check_eq("s2_left1", 32'(pending), 32'h02);
        check_eq("s2_dir_still_up", 32'(dir_up), 32'd1);
        tick();
        check_eq("s2_reverse", 32'({state, dir_up}), 32'({c_down, 1'b0}));
        wait_state("s2_open1", c_open);
        check_eq("s2_floor1", 32'(cur_floor), 32'd1);
        wait_state("s2_idle1", c_idle);
        check_eq("s2_pending0", 32'(pending), 32'd0);
        check_eq("s2_dir_down", 32'(dir_up), 32'd0);

        // Same-floor call during door wait extends the wait
        request(4'd3);
        wait_state("s3_wait", c_wait);
        check_eq("s3_floor3", 32'(cur_floor), 32'd3);
        tick();
        tick();
        request(4'd3);
        check_eq("s3_not_latched", 32'(pending), 32'd0);
        check_eq("s3_still_wait", 32'(state), 32'(c_wait));
        count_state(c_wait, n_cyc);
        check_eq("s3_extended", 32'(n_cyc), 32'd4);
        check_eq("s3_close", 32'(state), 32'(c_close));

        // Emergency stop mid-travel
        rst = 1'b1;
        tick();
        rst = 1'b0;
        request(4'd4);
        wait_floor("s4_at2", 4'd2);
        check_eq("s4_moving", 32'(state), 32'(c_up));
        estop = 1'b1;
        tick();
        check_eq("s4_estop", 32'(state), 32'(c_estop));
        check_eq("s4_cmds", 32'({motor_up, motor_down, door_open, door_wait, door_close}), 32'b00001);
        check_eq("s4_floor_kept", 32'(cur_floor), 32'd2);
        check_eq("s4_pending_kept", 32'(pending), 32'h10);
        request(4'd6);
        check_eq("s4_latched_in_estop", 32'(pending), 32'h50);
        check_eq("s4_held", 32'(state), 32'(c_estop));
        estop = 1'b0;
        tick();
        check_eq("s4_release_idle", 32'(state), 32'(c_idle));
        tick();
        check_eq("s4_resume", 32'(state), 32'(c_up));
        wait_state("s4_open4", c_open);
        check_eq("s4_floor4", 32'(cur_floor), 32'd4);

        // Out-of-range calls ignored, top floor accepted
        rst = 1'b1;
        tick();
        rst = 1'b0;
        request(4'd9);
        check_eq("s5_ignore9", 32'(pending), 32'd0);
        check_eq("s5_idle", 32'(state), 32'(c_idle));
        request(4'd8);
        check_eq("s5_ignore8", 32'(pending), 32'd0);
        request(4'd7);
        check_eq("s5_accept7", 32'(pending), 32'h80);
        wait_state("s5_open7", c_open);
        check_eq("s5_floor7", 32'(cur_floor), 32'd7);
        wait_state("s5_idle7", c_idle);

        // Reset (with estop) while moving down at floor 5
        request(4'd2);
        wait_floor("s6_at5", 4'd5);
        check_eq("s6_moving_down", 32'(state), 32'(c_down));
        rst   = 1'b1;
        estop = 1'b1;
        tick();
        check_eq("s6_state", 32'(state), 32'(c_idle));
        check_eq("s6_floor", 32'(cur_floor), 32'd0);
        check_eq("s6_pending", 32'(pending), 32'd0);
        check_eq("s6_dir", 32'(dir_up), 32'd1);
        check_eq("s6_cmds", 32'({motor_up, motor_down, door_open, door_wait, door_close}), 32'b00001);
        rst   = 1'b0;
        estop = 1'b0;
        tick();
        check_eq("s6_after", 32'(state), 32'(c_idle));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/elevator_scheduler.md
ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_FLOORS, default 8, number of served floors (2..64).
REQ-002 The block SHALL have parameter FLOOR_W, default 3, floor-index width, equal to ceil(log2(NUM_FLOORS)).
REQ-003 The block SHALL have parameter TRAVEL_CYCLES, default 8, clock cycles per one-floor move (>=1).
REQ-004 The block SHALL have parameter DOOR_CYCLES, default 16, clock cycles door is held open (>=1).
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 Port clk  input  1  rising-edge clock.
REQ-007 Port rst  input  1  synchronous active-high reset.
REQ-008 Port req_valid  input  1  floor call strobe, one request per asserted cycle.
REQ-009 Port req_floor  input  FLOOR_W  requested floor index.
REQ-010 Port estop  input  1  emergency stop, level-sensitive.
REQ-011 Port motor_up, motor_down  output  1 each  car drive commands.
REQ-012 Port door_open, door_wait, door_close  output  1 each  door commands.
REQ-013 Port cur_floor  output  FLOOR_W  current car floor.
REQ-014 Port dir_up  output  1  scan direction (1 = up).
REQ-015 Port pending  output  NUM_FLOORS  latched outstanding requests, bit i = floor i.
REQ-016 Port state  output  3  encoded FSM state.

Function
REQ-017 States SHALL be IDLE=0, MOVE_UP=1, MOVE_DOWN=2, DOOR_OPEN=3, DOOR_WAIT=4, DOOR_CLOSE=5, ESTOP=6; code 7 SHALL go to IDLE next cycle.
REQ-018 Motor/door outputs SHALL decode from the state register only (Moore): MOVE_UP -> motor_up; MOVE_DOWN -> motor_down; DOOR_OPEN -> door_open; DOOR_WAIT -> door_open+door_wait; IDLE/DOOR_CLOSE/ESTOP -> door_close; all other outputs 0.
REQ-019 req_valid with req_floor < NUM_FLOORS SHALL set pending[req_floor] at the next edge; req_floor >= NUM_FLOORS SHALL be ignored.
REQ-020 Exception: request for cur_floor while in DOOR_OPEN or DOOR_WAIT SHALL NOT be latched and SHALL reload the door counter to DOOR_CYCLES.
REQ-021 IDLE: pending[cur_floor] -> DOOR_OPEN; else requests ahead in dir_up direction -> move that way; else requests behind -> flip dir_up and move; else stay IDLE.
REQ-022 On entering MOVE_UP/MOVE_DOWN the travel counter SHALL load TRAVEL_CYCLES; after TRAVEL_CYCLES cycles in state cur_floor SHALL step +/-1.
REQ-023 On the step cycle: pending[new floor] (including a request arriving that cycle) -> DOOR_OPEN; else continue moving same direction with counter reloaded.
REQ-024 cur_floor SHALL never go below 0 nor above NUM_FLOORS-1; MOVE_UP at top floor or MOVE_DOWN at floor 0 SHALL go to IDLE without stepping.
REQ-025 DOOR_OPEN SHALL last one cycle, clear pending[cur_floor], load door counter with DOOR_CYCLES, then go DOOR_WAIT.
REQ-026 DOOR_WAIT SHALL last DOOR_CYCLES cycles (plus reloads per REQ-020), then DOOR_CLOSE for one cycle, then IDLE.
REQ-027 estop=1 SHALL force ESTOP at next edge from any state; travel/door counters clear; cur_floor, dir_up, pending retained; requests still latched.
REQ-028 ESTOP SHALL remain while estop=1 and go to IDLE on the first edge with estop=0.
REQ-029 Simultaneous estop and rst: rst SHALL win.

Reset
REQ-030 rst=1 at an edge SHALL set state=IDLE, cur_floor=0, dir_up=1, pending=0, counters=0, door_close=1, other commands 0, regardless of current state.

Verification (TRAVEL_CYCLES=2, DOOR_CYCLES=4, NUM_FLOORS=8)
REQ-031 Reset, req floor 3 -> MOVE_UP 6 cycles, cur_floor 0->3, DOOR_OPEN 1, DOOR_WAIT 4, DOOR_CLOSE 1, IDLE, pending=0.
REQ-032 At floor 3 idle, reqs 5 and 1 same window, dir_up=1 -> serves 5 first, then flips, serves 1; dir_up=0 after.
REQ-033 In DOOR_WAIT at floor 3, req 3 on 3rd wait cycle -> wait extended to 4 cycles after request, pending[3] stays 0.
REQ-034 Moving 0->4, estop mid-travel at floor 2 -> ESTOP, motors 0, door_close 1, pending[4] kept; release -> IDLE -> resumes to 4.
REQ-035 req_floor=9 (NUM_FLOORS=8 build with FLOOR_W=4) -> pending unchanged, state IDLE.
REQ-036 rst asserted in MOVE_DOWN at floor 5 -> next cycle IDLE, cur_floor=0, pending=0.
